fifo_dispatch_writer: RTL and testbench
=======================================

Name: fifo_dispatch_writer

Overview:
- Write-side master for the d0/d1 class FIFOs. It pops words from an upstream source FIFO and routes each word by a class bit, pushing it into d0 or d1.
- It honours each destination's fifo_pause (almost-full) flow-control output and never pushes into a paused destination.
- It sits between the shared ingress FIFO and the per-class fifo_d0/fifo_d1 instances.
- It provides per-destination word counters and a stall counter for the bench.

Parameters:
- DATA_SIZE, 6, word width in bits.
- DEST_BIT, 4, index of the data bit that selects the destination (0 selects d0, 1 selects d1).
- CNT_WIDTH, 8, width of the statistics counters.

Ports:
- clk  in  1  rising-edge clock.
- reset_L  in  1  synchronous, active-low reset.
- enable  in  1  permits new pops from the source.
- src_empty  in  1  source FIFO empty flag.
- src_data  in  DATA_SIZE  source FIFO registered pop data, valid in the cycle after pop_src.
- pop_src  out  1  pop strobe to the source FIFO.
- fifo_pause_d0  in  1  d0 almost-full/pause flag.
- fifo_pause_d1  in  1  d1 almost-full/pause flag.
- push_d0  out  1  push strobe to d0.
- data_d0  out  DATA_SIZE  push data to d0.
- push_d1  out  1  push strobe to d1.
- data_d1  out  DATA_SIZE  push data to d1.
- cnt_d0  out  CNT_WIDTH  words pushed to d0.
- cnt_d1  out  CNT_WIDTH  words pushed to d1.
- stall_cnt  out  CNT_WIDTH  cycles spent in ROUTE with the selected destination paused.
- busy  out  1  high when state is not IDLE.

Behaviour:
- Reset: checked on the clk edge only. While reset_L=0:
  - state goes to IDLE; the hold register and all counters clear to 0.
  - pop_src, push_d0, push_d1, data_d0, data_d1 and busy are all 0.
- Reset mid-operation: an in-flight word is dropped, with no push.
- State machine (registered state; strobes are combinational from state and inputs):
  - IDLE: pop_src = enable & ~src_empty. If pop_src, go to WAIT; otherwise stay.
  - WAIT: src_data is sampled into hold on the next edge; go to ROUTE. No pop and no push in this state.
  - ROUTE: sel = hold[DEST_BIT]. ready = ~fifo_pause_d{sel}.
    - If ready:
      - push_d{sel} = 1 and data_d{sel} = hold.
      - cnt_d{sel} increments.
      - pop_src = enable & ~src_empty in the same cycle. If pop_src, go to WAIT; otherwise go to IDLE.
    - If not ready: hold state; push and pop both 0; stall_cnt increments.
- Throughput: one word per 2 cycles when not stalled.
- Latency: pop in cycle N, push earliest in cycle N+2.
- Data outputs: data_dX = hold when push_dX=1, else 0. push_d0 and push_d1 are never high in the same cycle.
- Pause sampling: pause is sampled in the same cycle as the push decision. The destination's own threshold margin absorbs its one-cycle pause update.
- enable deasserted in WAIT or ROUTE: the current word still completes; no further pop is issued.
- src_empty rising while in ROUTE: push completes; the next state is IDLE.
- Pause of the non-selected destination has no effect.
- Counters: wrap modulo 2^CNT_WIDTH with no saturation. stall_cnt counts cycles, not words.
- Ordering: words leave in source order. A paused d1 head word blocks d0 traffic (no bypass, by design).
- busy = (state != IDLE).

Test Plan:
- Basic routing: reset, then source holds 0x05 and 0x15 (bit4 = 0 and 1), enable=1, no pause:
  - push_d0 with 0x05 two cycles after the first pop; push_d1 with 0x15 two cycles later.
  - cnt_d0=1, cnt_d1=1, stall_cnt=0.
- Stall: source holds 0x12; fifo_pause_d1=1 for 5 cycles, then 0:
  - design stays in ROUTE with no pushes for 5 cycles; stall_cnt=5.
  - push_d1 with data 0x12 occurs in the first cycle pause is low.
- Back-to-back: 4 words 0x01, 0x11, 0x02, 0x12 pushed into the source, no pause:
  - pops occur every 2 cycles; pushes alternate d0, d1, d0, d1 in order.
  - busy stays high throughout; pop_src is high in the same cycles as pushes 1–3.
- Enable drop: deassert enable in the WAIT cycle of word 0x03 with 3 more words in the source:
  - 0x03 is pushed to d0; no further pop occurs; state ends in IDLE with busy=0.
- Reset mid-word: assert reset_L=0 in ROUTE with hold=0x14:
  - no push occurs; all outputs and counters are 0 on the next edge.
  - after release, normal operation resumes from IDLE.
- Counter wrap: with CNT_WIDTH=8, push 256 words to d0 → cnt_d0 returns to 0.

Source files
------------

// File: rtl/fifo_dispatch_writer_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_dispatch_writer_if
// Purpose  : Source-pop / class-FIFO-push bundle for fifo_dispatch_writer.
// Revision : 1.0 - initial release
// ============================================================================
interface fifo_dispatch_writer_if #(
    parameter int DATA_SIZE = 6,
    parameter int CNT_WIDTH = 8
);
    logic                 enable;
    logic                 src_empty;
    logic [DATA_SIZE-1:0] src_data;
    logic                 pop_src;
    logic                 fifo_pause_d0;
    logic                 fifo_pause_d1;
    logic                 push_d0;
    logic [DATA_SIZE-1:0] data_d0;
    logic                 push_d1;
    logic [DATA_SIZE-1:0] data_d1;
    logic [CNT_WIDTH-1:0] cnt_d0;
    logic [CNT_WIDTH-1:0] cnt_d1;
    logic [CNT_WIDTH-1:0] stall_cnt;
    logic                 busy;

    modport master (
        input  enable, src_empty, src_data, fifo_pause_d0, fifo_pause_d1,
        output pop_src, push_d0, data_d0, push_d1, data_d1,
               cnt_d0, cnt_d1, stall_cnt, busy
    );

    modport slave (
        output enable, src_empty, src_data, fifo_pause_d0, fifo_pause_d1,
        input  pop_src, push_d0, data_d0, push_d1, data_d1,
               cnt_d0, cnt_d1, stall_cnt, busy
    );
endinterface
`default_nettype wire

// File: rtl/fifo_dispatch_writer.sv
`default_nettype none
// ============================================================================
// Module   : fifo_dispatch_writer
// Purpose  : Pops the ingress FIFO and routes each word to d0/d1 by class bit.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_dispatch_writer #(
    parameter int DATA_SIZE = 6,
    parameter int DEST_BIT  = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset_L,
    fifo_dispatch_writer_if.master  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_ROUTE = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t               r_state;
    state_t               w_next;
    logic [DATA_SIZE-1:0] r_hold;
    logic [CNT_WIDTH-1:0] r_cnt_d0;
    logic [CNT_WIDTH-1:0] r_cnt_d1;
    logic [CNT_WIDTH-1:0] r_stall_cnt;

    logic                 w_sel;
    logic                 w_ready;
    logic                 w_can_pop;
    logic                 w_pop;
    logic                 w_push_d0;
    logic                 w_push_d1;
    logic [DATA_SIZE-1:0] w_data_d0;
    logic [DATA_SIZE-1:0] w_data_d1;
    logic                 w_stall;

    // Strobes are forced low while reset_L is asserted so an in-flight word is dropped.
    always_comb begin
        w_next    = r_state;
        w_pop     = 1'b0;
        w_push_d0 = 1'b0;
        w_push_d1 = 1'b0;
        w_data_d0 = '0;
        w_data_d1 = '0;
        w_stall   = 1'b0;
        w_sel     = r_hold[DEST_BIT];
        w_ready   = w_sel ? ~bus.fifo_pause_d1 : ~bus.fifo_pause_d0;
        w_can_pop = bus.enable & ~bus.src_empty;
        if (reset_L) begin
            case (r_state)
                S_IDLE: begin
                    w_pop = w_can_pop;
                    if (w_can_pop) w_next = S_WAIT;
                end
                S_WAIT: begin
                    w_next = S_ROUTE;
                end
                S_ROUTE: begin
                    if (w_ready) begin
                        if (w_sel) begin
                            w_push_d1 = 1'b1;
                            w_data_d1 = r_hold;
                        end else begin
                            w_push_d0 = 1'b1;
                            w_data_d0 = r_hold;
                        end
                        w_pop  = w_can_pop;
                        w_next = w_can_pop ? S_WAIT : S_IDLE;
                    end else begin
                        w_stall = 1'b1;
                    end
                end
                default: begin
                    w_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            r_state     <= S_IDLE;
            r_hold      <= '0;
            r_cnt_d0    <= '0;
            r_cnt_d1    <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_next;
            // Source data is registered, so it is valid in the cycle after the pop.
            if (r_state == S_WAIT) r_hold <= bus.src_data;
            if (w_push_d0) r_cnt_d0 <= r_cnt_d0 + c_CNT_ONE;
            if (w_push_d1) r_cnt_d1 <= r_cnt_d1 + c_CNT_ONE;
            if (w_stall)   r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
        end
    end

    assign bus.pop_src   = w_pop;
    assign bus.push_d0   = w_push_d0;
    assign bus.data_d0   = w_data_d0;
    assign bus.push_d1   = w_push_d1;
    assign bus.data_d1   = w_data_d1;
    assign bus.cnt_d0    = r_cnt_d0;
    assign bus.cnt_d1    = r_cnt_d1;
    assign bus.stall_cnt = r_stall_cnt;
    assign bus.busy      = reset_L & (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fifo_dispatch_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_dispatch_writer
// Purpose  : Directed bench with source FIFO model and push scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fifo_dispatch_writer;

    localparam int DATA_SIZE = 6;
    localparam int DEST_BIT  = 4;
    localparam int CNT_WIDTH = 8;

    logic clk = 1'b0;
    logic reset_L;
    always #5 clk = ~clk;

    fifo_dispatch_writer_if #(.DATA_SIZE(DATA_SIZE), .CNT_WIDTH(CNT_WIDTH)) bus ();

    fifo_dispatch_writer #(
        .DATA_SIZE(DATA_SIZE),
        .DEST_BIT (DEST_BIT),
        .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk    (clk),
        .reset_L(reset_L),
        .bus    (bus.master)
    );

    int vectors     = 0;
    int miscompares = 0;
    int n_push_d0   = 0;

    logic [DATA_SIZE-1:0] src_q[$];
    logic [DATA_SIZE-1:0] exp_q[$];
    int                   src_count = 0;

    assign bus.src_empty = (src_count == 0);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic src_push(input logic [DATA_SIZE-1:0] d);
        src_q.push_back(d);
        src_count = src_q.size();
    endtask

    // Source FIFO: registered pop data; each popped word becomes an expected push.
    always @(posedge clk) begin
        if (bus.pop_src && src_q.size() > 0) begin
            logic [DATA_SIZE-1:0] w;
            w = src_q.pop_front();
            bus.src_data <= w;
            exp_q.push_back(w);
            src_count = src_q.size();
        end
    end

    // Output monitor: pushes must match the scoreboard in order and destination.
    always @(negedge clk) begin
        logic [DATA_SIZE-1:0] e;
        #2;
        if (!bus.push_d0) check("d0_data_idle", bus.data_d0, 0);
        if (!bus.push_d1) check("d1_data_idle", bus.data_d1, 0);
        if (bus.push_d0 || bus.push_d1) begin
            check("push_exclusive", bus.push_d0 & bus.push_d1, 0);
            if (exp_q.size() == 0) begin
                check("unexpected_push", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("push_dest", bus.push_d1, e[DEST_BIT]);
                check("push_data", bus.push_d1 ? bus.data_d1 : bus.data_d0, e);
                if (bus.push_d0) n_push_d0++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        bit done;
        reset_L           = 1'b0;
        bus.enable        = 1'b0;
        bus.fifo_pause_d0 = 1'b0;
        bus.fifo_pause_d1 = 1'b0;
        bus.src_data      = '0;
        repeat (2) @(negedge clk);

        // Reset: strobes gated even with a non-empty source and enable high
        src_push(6'h05);
        src_push(6'h15);
        bus.enable = 1'b1;
        #1;
        check("rst_pop", bus.pop_src, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_push0", bus.push_d0, 0);
        check("rst_push1", bus.push_d1, 0);
        check("rst_cnt0", bus.cnt_d0, 0);
        check("rst_cnt1", bus.cnt_d1, 0);
        check("rst_stall", bus.stall_cnt, 0);
        reset_L = 1'b1;
        #1;
        check("b_idle_pop", bus.pop_src, 1);

        // Basic routing: 0x05 -> d0, 0x15 -> d1, push two cycles after pop
        @(negedge clk); #1;
        check("b_wait_pop", bus.pop_src, 0);
        check("b_wait_push", bus.push_d0 | bus.push_d1, 0);
        check("b_wait_busy", bus.busy, 1);
        @(negedge clk); #1;
        check("b_push_d0", bus.push_d0, 1);
        check("b_data_d0", bus.data_d0, 6'h05);
        check("b_pop_2nd", bus.pop_src, 1);
        @(negedge clk); #1;
        check("b_cnt_d0", bus.cnt_d0, 1);
        @(negedge clk); #1;
        check("b_push_d1", bus.push_d1, 1);
        check("b_data_d1", bus.data_d1, 6'h15);
        check("b_no_pop", bus.pop_src, 0);
        @(negedge clk); #1;
        check("b_idle_busy", bus.busy, 0);
        check("b_cnt_d1", bus.cnt_d1, 1);
        check("b_stall0", bus.stall_cnt, 0);

        // Stall: d1 paused for 5 ROUTE cycles
        bus.fifo_pause_d1 = 1'b1;
        src_push(6'h12);
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("s_no_push", bus.push_d0 | bus.push_d1, 0);
            check("s_no_pop", bus.pop_src, 0);
            check("s_busy", bus.busy, 1);
            @(negedge clk);
        end
        bus.fifo_pause_d1 = 1'b0;
        bus.fifo_pause_d0 = 1'b1;
        #1;
        check("s_stall5", bus.stall_cnt, 5);
        check("s_push_d1", bus.push_d1, 1);
        check("s_data_d1", bus.data_d1, 6'h12);
        @(negedge clk); #1;
        check("s_cnt_d1", bus.cnt_d1, 2);
        check("s_idle", bus.busy, 0);
        bus.fifo_pause_d0 = 1'b0;

        // Back-to-back: alternating classes, pop overlaps pushes 1-3
        src_push(6'h01); src_push(6'h11); src_push(6'h02); src_push(6'h12);
        #1;
        check("bb_first_pop", bus.pop_src, 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            check("bb_wait_busy", bus.busy, 1);
            check("bb_wait_pop", bus.pop_src, 0);
            @(negedge clk); #1;
            check("bb_busy", bus.busy, 1);
            check("bb_push_d0", bus.push_d0, (k % 2) == 0);
            check("bb_push_d1", bus.push_d1, (k % 2) == 1);
            check("bb_pop", bus.pop_src, k < 3);
        end
        @(negedge clk); #1;
        check("bb_idle", bus.busy, 0);
        check("bb_cnt_d0", bus.cnt_d0, 3);
        check("bb_cnt_d1", bus.cnt_d1, 4);

        // Enable drop in WAIT of 0x03
        src_push(6'h03); src_push(6'h13); src_push(6'h04); src_push(6'h14);
        @(negedge clk);
        bus.enable = 1'b0;
        @(negedge clk); #1;
        check("e_push_d0", bus.push_d0, 1);
        check("e_data_d0", bus.data_d0, 6'h03);
        check("e_no_pop", bus.pop_src, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check("e_idle_busy", bus.busy, 0);
            check("e_idle_pop", bus.pop_src, 0);
        end
        check("e_src_left", src_count, 3);
        src_q.delete();
        src_count = 0;

        // Reset mid-word: hold 0x14 stalled in ROUTE
        bus.enable = 1'b1;
        bus.fifo_pause_d1 = 1'b1;
        src_push(6'h14);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); #1;
        check("r_in_route", bus.busy, 1);
        reset_L = 1'b0;
        bus.fifo_pause_d1 = 1'b0;
        #1;
        check("r_no_push1", bus.push_d1, 0);
        check("r_no_data1", bus.data_d1, 0);
        check("r_no_pop", bus.pop_src, 0);
        check("r_busy", bus.busy, 0);
        exp_q.delete();
        @(negedge clk); #1;
        check("r_cnt_d0", bus.cnt_d0, 0);
        check("r_cnt_d1", bus.cnt_d1, 0);
        check("r_stall", bus.stall_cnt, 0);
        check("r_no_push", bus.push_d0 | bus.push_d1, 0);
        reset_L = 1'b1;
        src_push(6'h08);
        @(negedge clk);
        @(negedge clk); #1;
        check("r_resume_push", bus.push_d0, 1);
        check("r_resume_data", bus.data_d0, 6'h08);
        @(negedge clk); #1;
        check("r_resume_cnt", bus.cnt_d0, 1);

        // Counter wrap: 256 d0 words from a clean reset
        reset_L = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_L = 1'b1;
        n_push_d0 = 0;
        for (int i = 0; i < 256; i++) begin
            logic [7:0] v;
            v = i[7:0];
            src_push({v[5], 1'b0, v[3:0]});
        end
        done = 1'b0;
        for (int c = 0; c < 2000 && !done; c++) begin
            @(negedge clk); #1;
            if (!bus.busy && src_count == 0) done = 1'b1;
        end
        check("w_drained", done, 1);
        check("w_pushes", n_push_d0, 256);
        check("w_cnt_d0", bus.cnt_d0, 0);
        check("w_cnt_d1", bus.cnt_d1, 0);
        check("w_stall", bus.stall_cnt, 0);
        check("w_exp_empty", exp_q.size(), 0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
